// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage load/store unit (master) and the memory (slave).
// A request is held with its payload stable until the cycle in which dmem_ready is high.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: formats byte/half/word accesses, runs the dmem handshake and stalls the pipe.
// Define MEM_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES cycles (mem_fault pulse, load returns 0).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_mem_read,
  input  logic                    mem_mem_write,
  input  logic [2:0]              mem_funct3,
  input  logic [31:0]             mem_alu_result,
  input  logic [31:0]             mem_write_data,
  output logic [31:0]             mem_read_result,
  output logic                    mem_stall,
  output logic                    mem_misaligned,
  output logic                    mem_fault,
  mem_access_unit_if.master       dmem
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nx;
  logic        access, is_load, misaligned, aligned_acc;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;
  logic [31:0] addr_p1, wdata_p1;
  logic [3:0]  be_p1;
  logic [2:0]  f3_p1;
  logic [1:0]  off_p1;
  logic        we_p1;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [31:0] ld_data;
  logic        ld_done, ld_zero, abort;

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = rdata >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'b000:  load_fmt = 32'(sb);
      3'b001:  load_fmt = 32'(shw);
      3'b100:  load_fmt = {24'd0, sh[7:0]};
      3'b101:  load_fmt = {16'd0, sh[15:0]};
      default: load_fmt = rdata;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  // Decode of the access currently presented by EX/MEM; a load wins over a store.
  assign access  = mem_mem_read | mem_mem_write;
  assign is_load = mem_mem_read;

  always_comb begin
    misaligned = 1'b0;
    case (mem_funct3[1:0])
      2'b01:   misaligned = mem_alu_result[0];
      2'b10:   misaligned = |mem_alu_result[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Gated by rst_n so an access held at the inputs cannot raise a request during reset.
  assign aligned_acc    = rst_n & access & ~misaligned;
  assign mem_misaligned = access & misaligned;
  assign cur_be         = is_load ? 4'b1111 : store_be(mem_funct3[1:0], mem_alu_result[1:0]);
  assign cur_wdata      = is_load ? 32'd0 : store_wdata(mem_funct3[1:0], mem_write_data);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] wait_cnt;

  assign abort = (state == WAIT) & ~dmem.dmem_ready & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if ((state == WAIT) && !dmem.dmem_ready && !abort)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
  assign abort              = 1'b0;
`endif

  assign mem_fault = abort;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (aligned_acc && !dmem.dmem_ready) state_nx = WAIT;
      WAIT:    if (dmem.dmem_ready || abort)         state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: IDLE drives the bus straight from EX/MEM, WAIT replays the latched request
  always_comb begin
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = 32'd0;
    dmem.dmem_be    = 4'd0;
    dmem.dmem_wdata = 32'd0;
    mem_stall       = 1'b0;
    case (state)
      IDLE: if (aligned_acc) begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = ~is_load;
        dmem.dmem_addr  = {mem_alu_result[31:2], 2'b00};
        dmem.dmem_be    = cur_be;
        dmem.dmem_wdata = cur_wdata;
        mem_stall       = ~dmem.dmem_ready;
      end
      WAIT: begin
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = we_p1;
        dmem.dmem_addr  = addr_p1;
        dmem.dmem_be    = be_p1;
        dmem.dmem_wdata = wdata_p1;
        mem_stall       = ~dmem.dmem_ready & ~abort;
      end
      default: ;
    endcase
  end

  assign ld_f3   = (state == WAIT) ? f3_p1  : mem_funct3;
  assign ld_off  = (state == WAIT) ? off_p1 : mem_alu_result[1:0];
  assign ld_data = load_fmt(ld_f3, ld_off, dmem.dmem_rdata);
  assign ld_done = dmem.dmem_req & dmem.dmem_ready & ~dmem.dmem_we;
  assign ld_zero = ((state == IDLE) & is_load & misaligned) | (abort & ~we_p1);

  // Request latch (IDLE -> WAIT) and MEM/WB load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1         <= 32'd0;
      wdata_p1        <= 32'd0;
      be_p1           <= 4'd0;
      f3_p1           <= 3'd0;
      off_p1          <= 2'd0;
      we_p1           <= 1'b0;
      mem_read_result <= 32'd0;
    end else begin
      if ((state == IDLE) && aligned_acc && !dmem.dmem_ready) begin
        addr_p1  <= {mem_alu_result[31:2], 2'b00};
        wdata_p1 <= cur_wdata;
        be_p1    <= cur_be;
        f3_p1    <= mem_funct3;
        off_p1   <= mem_alu_result[1:0];
        we_p1    <= ~is_load;
      end
      if (ld_done)
        mem_read_result <= ld_data;
      else if (ld_zero)
        mem_read_result <= 32'd0;
    end
  end

endmodule
